// File: rtl/uart_cmd_parser.sv
// Parses ASCII register-write commands of the form "R<0-3>:<hex>\r" from a UART
// byte stream and emits a one-cycle write strobe with address and data.
module uart_cmd_parser #(
    parameter int DP_WIDTH = 16,
    parameter int NUM_NIB  = DP_WIDTH / 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic [1:0]          o_wr_addr,
    output logic [DP_WIDTH-1:0] o_wr_data,
    output logic                o_wr_stb,
    output logic                o_err,
    output logic                o_busy
);

    localparam int CW = $clog2(NUM_NIB + 1);

    typedef enum logic [2:0] {IDLE, REG, COLON, NIB, ERR} state_t;

    state_t              state;
    logic [1:0]          addr_q;
    logic [DP_WIDTH-1:0] acc;
    logic [CW-1:0]       count;

    logic       is_hex;
    logic       is_eol;
    logic       is_r;
    logic       is_reg_digit;
    logic [3:0] nib;

    always_comb begin
        is_hex = 1'b1;
        nib    = 4'd0;
        if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39)
            nib = i_rx_data[3:0];
        else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                 (i_rx_data >= 8'h61 && i_rx_data <= 8'h66))
            nib = i_rx_data[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    assign is_eol       = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    assign is_r         = (i_rx_data == 8'h52) || (i_rx_data == 8'h72);
    assign is_reg_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h33);

    assign o_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= 2'd0;
            acc       <= '0;
            count     <= '0;
            o_wr_addr <= 2'd0;
            o_wr_data <= '0;
            o_wr_stb  <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_wr_stb <= 1'b0;
            o_err    <= 1'b0;
            if (i_rx_valid) begin
                case (state)
                    IDLE: begin
                        if (is_r) begin
                            state <= REG;
                            acc   <= '0;
                            count <= '0;
                        end else if (!is_eol) begin
                            state <= ERR;
                            o_err <= 1'b1;
                        end
                    end
                    REG: begin
                        if (is_reg_digit) begin
                            state  <= COLON;
                            addr_q <= i_rx_data[1:0];
                        end else begin
                            state <= ERR;
                            o_err <= 1'b1;
                        end
                    end
                    COLON: begin
                        if (i_rx_data == 8'h3A) begin
                            state <= NIB;
                        end else begin
                            state <= ERR;
                            o_err <= 1'b1;
                        end
                    end
                    NIB: begin
                        if (is_hex && count != CW'(NUM_NIB)) begin
                            acc   <= {acc[DP_WIDTH-5:0], nib};
                            count <= count + 1'b1;
                        end else if (is_eol && count != '0) begin
                            state     <= IDLE;
                            o_wr_stb  <= 1'b1;
                            o_wr_addr <= addr_q;
                            o_wr_data <= acc;
                        end else if (is_eol) begin
                            state <= IDLE;
                            o_err <= 1'b1;
                        end else begin
                            // overlong field or a non-hex byte
                            state <= ERR;
                            o_err <= 1'b1;
                        end
                    end
                    ERR: begin
                        if (is_eol)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: byte streams with hand-computed
// expected strobes, errors, address and data.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [1:0]  o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_wr_stb;
    logic        o_err;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic last_stb;
    logic last_err;
    int s0, e0;

    uart_cmd_parser #(.DP_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_wr_stb   (o_wr_stb),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_wr_stb) stb_cnt++;
        if (o_err) err_cnt++;
        if (o_wr_stb && o_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; drives one byte for one cycle, records the
    // pulses seen in the cycle after it was sampled, then idles gap cycles.
    task automatic send(input logic [7:0] b, input int gap);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge clk);
        last_stb   = o_wr_stb;
        last_err   = o_err;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic snap();
        s0 = stb_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        rst        = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = "R";
        repeat (3) @(negedge clk);
        chk("rst_stb",   o_wr_stb, 0);
        chk("rst_err",   o_err, 0);
        chk("rst_busy",  o_busy, 0);
        rst        = 1'b0;
        i_rx_valid = 1'b0;
        @(negedge clk);
        chk("rst_addr",  o_wr_addr, 0);
        chk("rst_data",  o_wr_data, 0);
        chk("rst_idle",  o_busy, 0);

        // slow stream with CRLF
        snap();
        send_str("R2:BEE", 15);
        send("F", 15);
        chk("slow_busy", o_busy, 1);
        send(8'h0D, 0);
        chk("slow_stb",  last_stb, 1);
        chk("slow_idle", o_busy, 0);
        send(8'h0A, 15);
        chk("slow_nstb", stb_cnt - s0, 1);
        chk("slow_nerr", err_cnt - e0, 0);
        chk("slow_addr", o_wr_addr, 2);
        chk("slow_data", o_wr_data, 16'hBEEF);

        // back-to-back, lowercase
        snap();
        send_str("r0:1a", 0);
        send(8'h0A, 2);
        chk("b2b_stb",   last_stb, 1);
        chk("b2b_addr",  o_wr_addr, 0);
        chk("b2b_data",  o_wr_data, 16'h001A);
        chk("b2b_nstb",  stb_cnt - s0, 1);

        // overlong field, then recovery
        snap();
        send_str("R3:1234", 0);
        send("5", 0);
        chk("long_err",  last_err, 1);
        chk("long_stb",  last_stb, 0);
        send(8'h0D, 2);
        chk("long_idle", o_busy, 0);
        chk("long_data", o_wr_data, 16'h001A);
        chk("long_nerr", err_cnt - e0, 1);
        chk("long_nstb", stb_cnt - s0, 0);
        send_str("R1:0007", 0);
        send(8'h0D, 2);
        chk("rec_stb",   last_stb, 1);
        chk("rec_addr",  o_wr_addr, 1);
        chk("rec_data",  o_wr_data, 16'h0007);

        // bad register number, then empty field
        snap();
        send("R", 0);
        send("4", 0);
        chk("reg4_err",  last_err, 1);
        send_str(":0000", 0);
        send(8'h0D, 2);
        chk("reg4_idle", o_busy, 0);
        chk("reg4_nerr", err_cnt - e0, 1);
        snap();
        send_str("R1:", 0);
        send(8'h0D, 2);
        chk("empty_err", last_err, 1);
        chk("empty_idle", o_busy, 0);
        chk("empty_nerr", err_cnt - e0, 1);
        chk("empty_nstb", stb_cnt - s0, 0);

        // non-hex digit in field
        snap();
        send_str("R0:1G", 0);
        chk("nonhex_err", last_err, 1);
        send(8'h0D, 2);
        chk("nonhex_nerr", err_cnt - e0, 1);
        chk("nonhex_data", o_wr_data, 16'h0007);

        // reset mid-command
        snap();
        send_str("R2:AB", 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_addr", o_wr_addr, 0);
        chk("mrst_data", o_wr_data, 0);
        chk("mrst_busy", o_busy, 0);
        send(8'h0D, 2);
        chk("mrst_cr_stb", last_stb, 0);
        chk("mrst_cr_err", last_err, 0);
        chk("mrst_nstb", stb_cnt - s0, 0);
        chk("mrst_nerr", err_cnt - e0, 0);
        send_str("R2:AB", 0);
        send(8'h0D, 2);
        chk("mrst_stb",  last_stb, 1);
        chk("mrst_addr2", o_wr_addr, 2);
        chk("mrst_data2", o_wr_data, 16'h00AB);

        // garbage then discarded command
        snap();
        send("X", 0);
        chk("junk_err",  last_err, 1);
        send_str("R1:FFFF", 0);
        chk("junk_busy", o_busy, 1);
        chk("junk_noerr", last_err, 0);
        send(8'h0D, 0);
        chk("junk_nostb", last_stb, 0);
        chk("junk_idle", o_busy, 0);
        send(8'h0D, 2);
        chk("junk_nstb", stb_cnt - s0, 0);
        chk("junk_nerr", err_cnt - e0, 1);
        chk("junk_data", o_wr_data, 16'h00AB);

        chk("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
